// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard for RAW hazard detection.
// Reads are combinational and can take same-cycle writeback data through the bypass path.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NRP      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt,
    input  logic [AW-1:0]       debug_addr,
    output logic [XLEN-1:0]     debug_data
);

    localparam int DEPTH = 2 ** AW;

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [AW:0]      r_cnt;

    logic             w_wr_q;
    logic             w_iss_q;
    logic             w_inc;
    logic             w_dec;
    logic [DEPTH-1:0] w_busy_nxt;

    // Register 0 swallows writes and issues when it is hardwired to zero.
    assign w_wr_q  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign w_iss_q = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
        end else if (w_wr_q) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Issue is applied after the writeback clear so a newer producer wins the race.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            if (w_wr_q)  w_busy_nxt[wr_addr]  = 1'b0;
            if (w_iss_q) w_busy_nxt[iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    // At most one set and one clear per cycle, so the count moves by -1/0/+1.
    assign w_inc = !flush && w_iss_q && !r_busy[iss_addr];
    assign w_dec = !flush && w_wr_q && r_busy[wr_addr] &&
                   !(w_iss_q && (iss_addr == wr_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_cnt <= '0;
        else if (flush)           r_cnt <= '0;
        else if (w_inc && !w_dec) r_cnt <= r_cnt + (AW+1)'(1);
        else if (w_dec && !w_inc) r_cnt <= r_cnt - (AW+1)'(1);
    end

    assign busy_cnt = r_cnt;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRP; k++) begin
            if ((ZERO_REG != 0) && (rd_addr[k*AW +: AW] == '0)) begin
                rd_data[k*XLEN +: XLEN] = '0;
                rd_busy[k]              = 1'b0;
            end else if ((BYPASS != 0) && w_wr_q && (wr_addr == rd_addr[k*AW +: AW])) begin
                rd_data[k*XLEN +: XLEN] = wr_data;
                rd_busy[k]              = 1'b0;
            end else begin
                rd_data[k*XLEN +: XLEN] = r_mem[rd_addr[k*AW +: AW]];
                rd_busy[k]              = r_busy[rd_addr[k*AW +: AW]];
            end
        end
    end

    assign debug_data = r_mem[debug_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default, no-bypass and narrow 3-port configurations.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        flush;
    logic [4:0]  debug_addr;

    logic [63:0] rdA, rdB;
    logic [1:0]  rbA, rbB;
    logic [5:0]  cntA, cntB;
    logic [31:0] dbgA, dbgB;

    logic [8:0]  c_rd_addr;
    logic [47:0] c_rd_data;
    logic [2:0]  c_rd_busy;
    logic        c_wr_en;
    logic [2:0]  c_wr_addr;
    logic [15:0] c_wr_data;
    logic        c_iss_en;
    logic [2:0]  c_iss_addr;
    logic        c_flush;
    logic [3:0]  c_cnt;
    logic [2:0]  c_dbg_addr;
    logic [15:0] c_dbg_data;

    regfile_sb #(.XLEN(32), .AW(5), .NRP(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdA), .rd_busy(rbA),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .busy_cnt(cntA), .debug_addr(debug_addr), .debug_data(dbgA)
    );

    regfile_sb #(.XLEN(32), .AW(5), .NRP(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdB), .rd_busy(rbB),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
        .busy_cnt(cntB), .debug_addr(debug_addr), .debug_data(dbgB)
    );

    regfile_sb #(.XLEN(16), .AW(3), .NRP(3), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .rst(rst), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .iss_en(c_iss_en), .iss_addr(c_iss_addr), .flush(c_flush),
        .busy_cnt(c_cnt), .debug_addr(c_dbg_addr), .debug_data(c_dbg_data)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_chk  = 0;

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic cmp(input logic [63:0] obs);
        exp_t e;
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0; debug_addr = '0;
        c_rd_addr = '0; c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0;
        c_iss_en = 1'b0; c_iss_addr = '0; c_flush = 1'b0; c_dbg_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        push("rst_cnt", 64'd0);  cmp(64'(cntA));
        push("rst_rd", 64'd0);   cmp(rdA);
        push("rst_busy", 64'd0); cmp(64'(rbA));

        // write then read, with and without bypass
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h12345678; rd_addr = {5'd3, 5'd3};
        #1;
        push("byp_data", {2{32'h12345678}}); cmp(rdA);
        push("byp_busy", 64'd0);             cmp(64'(rbA));
        push("nobyp_data", 64'd0);           cmp(rdB);
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        push("arr_data", {2{32'h12345678}});       cmp(rdA);
        push("arr_data_nobyp", {2{32'h12345678}}); cmp(rdB);

        // zero register
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        iss_en = 1'b1; iss_addr = 5'd0; rd_addr = {5'd0, 5'd0};
        #1;
        push("zr_data", 64'd0); cmp(rdA);
        push("zr_busy", 64'd0); cmp(64'(rbA));
        @(negedge clk);
        wr_en = 1'b0; iss_en = 1'b0; debug_addr = 5'd0;
        #1;
        push("zr_cnt", 64'd0);  cmp(64'(cntA));
        push("zr_dbg", 64'd0);  cmp(64'(dbgA));
        push("zr_dbgB", 64'd0); cmp(64'(dbgB));

        // scoreboard count
        for (int i = 1; i <= 3; i++) begin
            iss_en = 1'b1; iss_addr = i[4:0];
            @(negedge clk);
            push("cnt_iss", 64'(i)); cmp(64'(cntA));
        end
        iss_en = 1'b0; rd_addr = {5'd3, 5'd2};
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22;
        #1;
        push("sb_busy_byp", 64'b10);   cmp(64'(rbA));
        push("sb_busy_nobyp", 64'b11); cmp(64'(rbB));
        @(negedge clk);
        push("cnt_wr", 64'd2); cmp(64'(cntA));
        wr_addr = 5'd9; wr_data = 32'h99;
        @(negedge clk);
        wr_en = 1'b0;
        push("cnt_wr_idle", 64'd2); cmp(64'(cntA));
        push("cnt_nobyp", 64'd2);   cmp(64'(cntB));

        // flush with concurrent issue and write
        flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd6;
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h55;
        @(negedge clk);
        flush = 1'b0; iss_en = 1'b0; wr_en = 1'b0; rd_addr = {5'd6, 5'd1};
        #1;
        push("fl_cnt", 64'd0);           cmp(64'(cntA));
        push("fl_data", {32'h0, 32'h55}); cmp(rdA);
        push("fl_busy", 64'd0);          cmp(64'(rbA));
        rd_addr = {5'd3, 5'd3};
        #1;
        push("fl_busy_r3", 64'd0); cmp(64'(rbA));

        // issue/writeback race
        @(negedge clk);
        iss_en = 1'b1; iss_addr = 5'd4;
        @(negedge clk);
        iss_en = 1'b0;
        repeat (2) @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hA5;
        iss_en = 1'b1; iss_addr = 5'd4; rd_addr = {5'd4, 5'd4};
        #1;
        push("race_byp_data", {2{32'hA5}}); cmp(rdA);
        push("race_byp_busy", 64'd0);       cmp(64'(rbA));
        @(negedge clk);
        wr_en = 1'b0; iss_en = 1'b0; debug_addr = 5'd4;
        #1;
        push("race_busy", 64'b11);  cmp(64'(rbA));
        push("race_dbg", 64'hA5);   cmp(64'(dbgA));
        push("race_cnt", 64'd1);    cmp(64'(cntA));
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hB6;
        iss_en = 1'b1; iss_addr = 5'd5;
        @(negedge clk);
        wr_en = 1'b0; iss_en = 1'b0; rd_addr = {5'd5, 5'd4};
        #1;
        push("net_busy", 64'b10); cmp(64'(rbA));
        push("net_cnt", 64'd1);   cmp(64'(cntA));

        // asynchronous reset mid-operation
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        iss_en = 1'b1; iss_addr = 5'd7;
        @(negedge clk);
        wr_en = 1'b0; iss_en = 1'b0; rd_addr = {5'd7, 5'd5};
        #1;
        push("pre_rst_data", {32'h0, 32'hDEADBEEF}); cmp(rdA);
        push("pre_rst_busy", 64'b10);                cmp(64'(rbA));
        push("pre_rst_cnt", 64'd1);                  cmp(64'(cntA));
        #1;
        rst = 1'b1;
        #1;
        push("arst_data", 64'd0); cmp(rdA);
        push("arst_busy", 64'd0); cmp(64'(rbA));
        push("arst_cnt", 64'd0);  cmp(64'(cntA));
        @(negedge clk);
        rst = 1'b0;

        // three read ports, narrow configuration
        c_wr_en = 1'b1; c_wr_addr = 3'd2; c_wr_data = 16'hBEEF;
        @(negedge clk);
        c_wr_addr = 3'd5; c_wr_data = 16'h1234; c_iss_en = 1'b1; c_iss_addr = 3'd5;
        @(negedge clk);
        c_wr_en = 1'b0; c_iss_en = 1'b0; c_rd_addr = {3'd2, 3'd5, 3'd2}; c_dbg_addr = 3'd2;
        #1;
        push("c_data", {16'h0, 16'hBEEF, 16'h1234, 16'hBEEF}); cmp(64'(c_rd_data));
        push("c_busy", 64'b010);   cmp(64'(c_rd_busy));
        push("c_cnt", 64'd1);      cmp(64'(c_cnt));
        push("c_dbg", 64'hBEEF);   cmp(64'(c_dbg_data));
        c_rd_addr = {3'd0, 3'd5, 3'd5};
        #1;
        push("c_data_same", {16'h0, 16'h0, 16'h1234, 16'h1234}); cmp(64'(c_rd_data));
        push("c_busy_same", 64'b011); cmp(64'(c_rd_busy));
        c_wr_en = 1'b1; c_wr_addr = 3'd5; c_wr_data = 16'h7777;
        #1;
        push("c_byp_data", {16'h0, 16'h0, 16'h7777, 16'h7777}); cmp(64'(c_rd_data));
        push("c_byp_busy", 64'b000); cmp(64'(c_rd_busy));
        @(negedge clk);
        c_wr_en = 1'b0;
        #1;
        push("c_cnt_clr", 64'd0); cmp(64'(c_cnt));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised register file for the pipelined CPU: configurable data width, depth and number of read ports.
- Integrated scoreboard of per-register busy bits. The decode stage uses them to detect RAW hazards against in-flight producers.
- Writes commit on posedge clk. Same-cycle writeback data is forwarded to the read ports, replacing the old negedge double-bump scheme.
- Sits between decode (reads, issue marking) and writeback (write, busy clear).

Parameters:
- XLEN, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NRP, 2, number of combinational read ports.
- ZERO_REG, 1, if 1 then register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, if 1 then same-cycle write data is forwarded to matching read ports.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- rst, input, 1, reset, asynchronous, active-high.
- rd_addr, input, NRP*AW, read addresses; port k uses bits [k*AW +: AW].
- rd_data, output, NRP*XLEN, read data; port k uses bits [k*XLEN +: XLEN].
- rd_busy, output, NRP, port k's register has an outstanding producer.
- wr_en, input, 1, writeback write enable.
- wr_addr, input, AW, writeback destination.
- wr_data, input, XLEN, writeback data.
- iss_en, input, 1, an instruction issues with destination iss_addr.
- iss_addr, input, AW, destination to mark busy.
- flush, input, 1, pipeline flush; clears all busy bits.
- busy_cnt, output, AW+1, registered count of busy registers.
- debug_addr, input, AW, debug read address.
- debug_data, output, XLEN, debug read data, raw array content with no bypass.

Behaviour:
- Reset (async, rst=1): all 2**AW data registers = 0, all busy bits = 0, busy_cnt = 0. Combinational outputs then read 0 / not busy.
- Address zero: a qualifying write or issue means the addr is not zero when ZERO_REG=1. With ZERO_REG=0, register 0 behaves like any other register.
- Read, per port k, combinational, zero latency:
  - ZERO_REG=1 and addr=0 -> rd_data=0, rd_busy=0.
  - Else if BYPASS=1 and a qualifying wr_en hits this addr -> rd_data=wr_data, rd_busy=0.
  - Else -> rd_data=array[addr], rd_busy=busy[addr].
- Write: on posedge, a qualifying wr_en sets array[wr_addr] <= wr_data. Written data is visible from the next cycle, or in the same cycle via bypass.
- Scoreboard next state, evaluated per register r at posedge, first match wins:
  1. flush=1 -> busy[r]=0. Issue in the same cycle is ignored; the write still commits data.
  2. Qualifying iss_en with iss_addr=r -> busy[r]=1. This holds even if a write to r occurs in the same cycle, because a newer producer supersedes.
  3. Qualifying wr_en with wr_addr=r -> busy[r]=0.
  4. Otherwise busy[r] holds.
- Issue to an already-busy register: busy stays 1, no count change.
- Write to a non-busy register: data commits, busy stays 0.
- With BYPASS=0: same-cycle write is not forwarded, and rd_busy reflects the pre-clock busy bit.
- busy_cnt tracks the population count of busy bits:
  - Updated incrementally at posedge: +1 when a clear bit becomes set, -1 when a set bit clears, net 0 when both happen.
  - Set to 0 on flush.
  - Must always equal popcount(busy) one cycle after any update.
  - Never exceeds 2**AW; never underflows.
- Multiple read ports may address the same register, each with identical results.

Test Plan:
- Reset mid-operation: write 0xDEADBEEF to r5, mark r7 busy, then assert rst asynchronously between edges -> rd_data(r5)=0, busy cleared immediately, busy_cnt=0 without a clock edge.
- Write then read: wr r3=0x12345678 -> same cycle port0 reads 0x12345678 with rd_busy=0 (bypass); next cycle reads the same from the array. Repeat with BYPASS=0 -> same cycle returns the old value 0.
- Zero register: wr r0=0xFFFFFFFF and iss r0 -> port reads 0, rd_busy=0, busy_cnt unchanged at 0.
- Issue/writeback race: iss r4 at cycle 0; at cycle 3, wr r4=0xA5 together with iss r4 -> after the edge busy[4]=1, data=0xA5, busy_cnt=1.
- Scoreboard count: iss r1, r2, r3 on consecutive cycles -> busy_cnt 1,2,3. Then wr r2 -> 2; wr r9 (not busy) -> 2.
- Flush: with r1 and r3 busy, assert flush with iss r6 and wr r1=0x55 -> all busy=0, busy_cnt=0, r1=0x55, r6 not busy.
- NRP=3, AW=3, XLEN=16: three ports read the same and different addresses -> independent, correct data and busy flags.
